// File: rtl/instr_stream_encoder_if.sv
// Bundles the field-tuple stream, session control and instruction-memory write port
// of instr_stream_encoder. The encoder uses the slave modport; the loader side uses master.
interface instr_stream_encoder_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [2:0]        in_kind;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [12:0]       in_imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   count;

    modport master (
        output start, base_addr, in_valid, in_last, in_kind, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm,
        input  in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, count
    );

    modport slave (
        input  start, base_addr, in_valid, in_last, in_kind, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm,
        output in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, count
    );
endinterface

// File: rtl/instr_stream_encoder.sv
// Packs decoded RV32I field tuples (R, I-ALU, LOAD, STORE, BRANCH) into instruction words
// and writes them to consecutive imem addresses. Define ENCODER_RANGE_CHECK_EN to reject
// out-of-range immediates and odd branch offsets.
module instr_stream_encoder #(
    parameter int unsigned ADDR_W = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    instr_stream_encoder_if.slave bus
);
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpIAlu   = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    typedef enum logic [1:0] {StIdle, StAccept, StWrite, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              last_q, last_d;

    logic [31:0] enc_word;
    logic        kind_ok;
    logic        imm_ok;
    logic        legal;

    always_comb begin
        enc_word = '0;
        case (bus.in_kind)
            3'd0: enc_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                              bus.in_rd, OpR};
            3'd1: enc_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OpIAlu};
            3'd2: enc_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OpLoad};
            3'd3: enc_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                              bus.in_imm[4:0], OpStore};
            3'd4: enc_word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1,
                              bus.in_funct3, bus.in_imm[4:1], bus.in_imm[11], OpBranch};
            default: enc_word = '0;
        endcase
    end

    assign kind_ok = (bus.in_kind <= 3'd4);

`ifdef ENCODER_RANGE_CHECK_EN
    always_comb begin
        imm_ok = 1'b1;
        if (bus.in_kind inside {3'd1, 3'd2, 3'd3}) begin
            imm_ok = (bus.in_imm[12] == bus.in_imm[11]);
        end else if (bus.in_kind == 3'd4) begin
            imm_ok = ~bus.in_imm[0];
        end
    end
`else
    // Branch offsets are halfword multiples; bit 0 carries no information when unchecked.
    logic unused_imm0;
    assign unused_imm0 = bus.in_imm[0];
    assign imm_ok      = 1'b1;
`endif

    assign legal = kind_ok & imm_ok;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    addr_d  = bus.base_addr;
                    count_d = '0;
                    err_d   = 1'b0;
                    state_d = StAccept;
                end
            end
            StAccept: begin
                if (bus.in_valid) begin
                    if (legal) begin
                        wdata_d = enc_word;
                        last_d  = bus.in_last;
                        state_d = StWrite;
                    end else begin
                        err_d = 1'b1;
                        if (bus.in_last) begin
                            state_d = StDone;
                        end
                    end
                end
            end
            StWrite: begin
                count_d = count_q + 1'b1;
                // The top word is the last one that fits; the session ends without wrapping.
                if (&addr_q) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = last_q ? StDone : StAccept;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            count_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            last_q  <= last_d;
        end
    end

    assign bus.in_ready   = (state_q == StAccept);
    assign bus.imem_we    = (state_q == StWrite);
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.busy       = (state_q != StIdle);
    assign bus.done       = (state_q == StDone);
    assign bus.err        = err_q;
    assign bus.count      = count_q;
endmodule

// File: tb/tb_instr_stream_encoder.sv
// Directed bench for instr_stream_encoder: hand-encoded RV32I words, session control,
// illegal tuples, address overflow and mid-write reset.
module tb_instr_stream_encoder;
    localparam int unsigned ADDR_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_stream_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    instr_stream_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail = 0;
    int done_cnt = 0;
    logic [ADDR_W-1:0] wr_addr[$];
    logic [31:0] wr_data[$];

    // Record every completed write and done pulse
    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.imem_we) begin
                wr_addr.push_back(bus.imem_addr);
                wr_data.push_back(bus.imem_wdata);
            end
            if (bus.done) done_cnt++;
        end
    end

    always @(negedge clk) begin
        if (rst_n && (bus.in_ready || bus.imem_we)) begin
            n_checks++;
            if (bus.in_ready && bus.imem_we) begin
                n_fail++;
                $display("FAIL ready_we_overlap: got in_ready=1 imem_we=1 expected not both");
            end
        end
    end

    function automatic logic [ADDR_W-1:0] wa(input int k);
        return (k < wr_addr.size()) ? wr_addr[k] : 'x;
    endfunction

    function automatic logic [31:0] wd(input int k);
        return (k < wr_data.size()) ? wr_data[k] : 'x;
    endfunction

    task automatic idle_inputs();
        bus.start = 1'b0;     bus.base_addr = '0;  bus.in_valid = 1'b0; bus.in_last = 1'b0;
        bus.in_kind = '0;     bus.in_rd = '0;      bus.in_rs1 = '0;     bus.in_rs2 = '0;
        bus.in_funct3 = '0;   bus.in_funct7 = '0;  bus.in_imm = '0;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] base);
        bus.start = 1'b1;
        bus.base_addr = base;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [2:0] kind, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [12:0] imm, input logic last, output logic acc);
        bus.in_kind = kind; bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2;
        bus.in_funct3 = f3; bus.in_funct7 = f7; bus.in_imm = imm; bus.in_last = last;
        bus.in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            if (bus.in_ready) acc = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 50 && bus.busy; i++) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle_timeout: got busy=%b expected 0", name, bus.busy);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic test_reset();
        n_checks++;
        if ({bus.in_ready, bus.imem_we, bus.busy, bus.done, bus.err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {bus.in_ready, bus.imem_we, bus.busy, bus.done, bus.err});
        end
        n_checks++;
        if (bus.imem_addr !== 8'h00 || bus.imem_wdata !== 32'h0 || bus.count !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_values: got addr=%h wdata=%h count=%0d expected 0/0/0",
                     bus.imem_addr, bus.imem_wdata, bus.count);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stay_idle: got busy=%b expected 0", bus.busy);
        end
    endtask

    task automatic test_alu_seq();
        logic acc;
        int d0;
        clear_log();
        d0 = done_cnt;
        do_start(8'h10);
        n_checks++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL alu_after_start: got busy=%b ready=%b expected 1/1",
                     bus.busy, bus.in_ready);
        end
        send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'd5, 1'b0, acc);
        send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0, 1'b1, acc);
        wait_idle("alu");
        n_checks++;
        if (wr_addr.size() !== 2) begin
            n_fail++; $display("FAIL alu_nwrites: got %0d expected 2", wr_addr.size());
        end
        n_checks++;
        if (wa(0) !== 8'h10 || wd(0) !== 32'h00500093) begin
            n_fail++; $display("FAIL alu_w0: got %h@%h expected 00500093@10", wd(0), wa(0));
        end
        n_checks++;
        if (wa(1) !== 8'h11 || wd(1) !== 32'h002081B3) begin
            n_fail++; $display("FAIL alu_w1: got %h@%h expected 002081b3@11", wd(1), wa(1));
        end
        n_checks++;
        if (done_cnt - d0 !== 1 || bus.count !== 9'd2 || bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_status: got done=%0d count=%0d err=%b expected 1/2/0",
                     done_cnt - d0, bus.count, bus.err);
        end
    endtask

    task automatic test_store_load();
        logic acc;
        clear_log();
        do_start(8'h40);
        send(3'd3, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 13'd8, 1'b0, acc);
        // One cycle after the handshake the word is on the write port and ready is low
        n_checks++;
        if (bus.imem_we !== 1'b1 || bus.in_ready !== 1'b0 || bus.imem_addr !== 8'h40 ||
            bus.imem_wdata !== 32'h0020A423) begin
            n_fail++;
            $display("FAIL sw_write_cycle: got we=%b rdy=%b %h@%h expected 1/0 0020a423@40",
                     bus.imem_we, bus.in_ready, bus.imem_wdata, bus.imem_addr);
        end
        send(3'd2, 5'd5, 5'd1, 5'd0, 3'd2, 7'd0, 13'd0, 1'b1, acc);
        wait_idle("sl");
        n_checks++;
        if (wa(1) !== 8'h41 || wd(1) !== 32'h0000A283 || wr_addr.size() !== 2) begin
            n_fail++;
            $display("FAIL lw_w1: got %h@%h n=%0d expected 0000a283@41 n=2",
                     wd(1), wa(1), wr_addr.size());
        end
    endtask

    task automatic test_branch_range();
        logic acc;
        int d0;
        clear_log();
        do_start(8'h50);
        send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h1FFC, 1'b1, acc);
        wait_idle("beq");
        n_checks++;
        if (wa(0) !== 8'h50 || wd(0) !== 32'hFE208EE3 || bus.count !== 9'd1) begin
            n_fail++;
            $display("FAIL beq_m4: got %h@%h count=%0d expected fe208ee3@50 count=1",
                     wd(0), wa(0), bus.count);
        end
        clear_log();
        d0 = done_cnt;
        do_start(8'h54);
        send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h1FFD, 1'b1, acc);
        wait_idle("beq_odd");
`ifdef ENCODER_RANGE_CHECK_EN
        n_checks++;
        if (wr_addr.size() !== 0 || bus.err !== 1'b1 || bus.count !== 9'd0 ||
            done_cnt - d0 !== 1) begin
            n_fail++;
            $display("FAIL beq_odd: got n=%0d err=%b count=%0d done=%0d expected 0/1/0/1",
                     wr_addr.size(), bus.err, bus.count, done_cnt - d0);
        end
`else
        n_checks++;
        if (wd(0) !== 32'hFE208EE3 || bus.err !== 1'b0 || bus.count !== 9'd1 ||
            done_cnt - d0 !== 1) begin
            n_fail++;
            $display("FAIL beq_odd: got %h err=%b count=%0d done=%0d expected fe208ee3/0/1/1",
                     wd(0), bus.err, bus.count, done_cnt - d0);
        end
`endif
        clear_log();
        do_start(8'h58);
        send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'h0800, 1'b1, acc);
        wait_idle("addi_big");
`ifdef ENCODER_RANGE_CHECK_EN
        n_checks++;
        if (wr_addr.size() !== 0 || bus.err !== 1'b1) begin
            n_fail++;
            $display("FAIL addi_big: got n=%0d err=%b expected 0/1", wr_addr.size(), bus.err);
        end
`else
        n_checks++;
        if (wd(0) !== 32'h80000093 || bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL addi_big: got %h err=%b expected 80000093/0", wd(0), bus.err);
        end
`endif
    endtask

    task automatic test_illegal_kind();
        logic acc;
        int d0;
        clear_log();
        d0 = done_cnt;
        do_start(8'h30);
        n_checks++;
        if (bus.err !== 1'b0) begin
            n_fail++; $display("FAIL ill_err_cleared: got %b expected 0", bus.err);
        end
        send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'd5, 1'b0, acc);
        send(3'd6, 5'd7, 5'd7, 5'd7, 3'd7, 7'h7F, 13'h1FFF, 1'b0, acc);
        n_checks++;
        if (acc !== 1'b1 || bus.imem_we !== 1'b0 || bus.err !== 1'b1) begin
            n_fail++;
            $display("FAIL ill_drop: got acc=%b we=%b err=%b expected 1/0/1",
                     acc, bus.imem_we, bus.err);
        end
        do_start(8'h99);  // start outside IDLE must be ignored
        send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0, 1'b1, acc);
        wait_idle("ill");
        n_checks++;
        if (wr_addr.size() !== 2 || wa(0) !== 8'h30 || wa(1) !== 8'h31 ||
            wd(1) !== 32'h002081B3) begin
            n_fail++;
            $display("FAIL ill_writes: got n=%0d %h@%h,%h@%h expected 2 ..@30,002081b3@31",
                     wr_addr.size(), wd(0), wa(0), wd(1), wa(1));
        end
        n_checks++;
        if (bus.err !== 1'b1 || bus.count !== 9'd2 || done_cnt - d0 !== 1) begin
            n_fail++;
            $display("FAIL ill_status: got err=%b count=%0d done=%0d expected 1/2/1",
                     bus.err, bus.count, done_cnt - d0);
        end
    endtask

    task automatic test_overflow();
        logic acc;
        int d0;
        clear_log();
        d0 = done_cnt;
        do_start(8'hFE);
        send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'd1, 1'b0, acc);
        send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'd2, 1'b0, acc);
        send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'd3, 1'b0, acc);
        n_checks++;
        if (acc !== 1'b0) begin
            n_fail++; $display("FAIL ovf_third_accepted: got %b expected 0", acc);
        end
        wait_idle("ovf");
        n_checks++;
        if (wr_addr.size() !== 2 || wa(0) !== 8'hFE || wd(0) !== 32'h00100093 ||
            wa(1) !== 8'hFF || wd(1) !== 32'h00200093) begin
            n_fail++;
            $display("FAIL ovf_writes: got n=%0d %h@%h,%h@%h expected 2 00100093@fe,00200093@ff",
                     wr_addr.size(), wd(0), wa(0), wd(1), wa(1));
        end
        n_checks++;
        if (bus.err !== 1'b1 || bus.count !== 9'd2 || done_cnt - d0 !== 1) begin
            n_fail++;
            $display("FAIL ovf_status: got err=%b count=%0d done=%0d expected 1/2/1",
                     bus.err, bus.count, done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid_write();
        logic acc;
        clear_log();
        do_start(8'h20);
        send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'd5, 1'b0, acc);
        n_checks++;
        if (bus.imem_we !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre_we: got %b expected 1", bus.imem_we);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.in_ready, bus.imem_we, bus.busy, bus.done, bus.err} !== 5'b0 ||
            bus.imem_addr !== 8'h00 || bus.imem_wdata !== 32'h0 || bus.count !== 9'd0) begin
            n_fail++;
            $display("FAIL rst_mid_write: got flags=%b addr=%h wdata=%h count=%0d expected 0",
                     {bus.in_ready, bus.imem_we, bus.busy, bus.done, bus.err},
                     bus.imem_addr, bus.imem_wdata, bus.count);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_start(8'h20);
        send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0, 1'b1, acc);
        wait_idle("rst");
        n_checks++;
        if (wr_addr.size() !== 1 || wa(0) !== 8'h20 || wd(0) !== 32'h002081B3 ||
            bus.count !== 9'd1 || bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_recover: got n=%0d %h@%h count=%0d err=%b expected 1 002081b3@20",
                     wr_addr.size(), wd(0), wa(0), bus.count, bus.err);
        end
    endtask

    initial begin
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_alu_seq();
        test_store_load();
        test_branch_range();
        test_illegal_kind();
        test_overflow();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/instr_stream_encoder.md
# instr_stream_encoder

Sequential instruction encoder and instruction-memory writer for the single-cycle RV32I core. It accepts decoded instruction fields (kind, registers, funct, immediate) over a valid/ready stream, packs each into a 32-bit RV32I word for the five formats the control path decodes (R, I-ALU, load, store, branch), and writes the words to consecutive instruction-memory locations. It is the program loader on the opposite side of the core's opcode decode, used by testbenches and boot logic before the core is released from reset.

## Interface
- ADDR_W, 8, word-address width of instruction memory
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a load session; sampled only in IDLE
- base_addr  in  ADDR_W  first word address of the session
- in_valid  in  1  field tuple valid
- in_ready  out  1  encoder can accept a tuple
- in_last  in  1  tuple is the final one of the session
- in_kind  in  3  0=R, 1=I-ALU, 2=LOAD, 3=STORE, 4=BRANCH; 5–7 illegal
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_funct3  in  3
- in_funct7  in  7  R-type only
- in_imm  in  13  signed immediate (byte offset for BRANCH)
- imem_we  out  1  one-cycle write strobe
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at session end
- err  out  1  sticky error, cleared by the next accepted start
- count  out  ADDR_W+1  words written in current/last session

## Operation
- Encodings: R = funct7|rs2|rs1|funct3|rd|0110011; I-ALU = imm[11:0]|rs1|funct3|rd|0010011; LOAD = same with opcode 0000011; STORE = imm[11:5]|rs2|rs1|funct3|imm[4:0]|0100011; BRANCH = imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|1100011. Unused fields of the tuple are ignored.
- FSM: IDLE, ACCEPT, WRITE, DONE.
- IDLE: start=1 → load addr←base_addr, count←0, err←0, go to ACCEPT.
- ACCEPT: in_ready=1. On in_valid: legal tuple → register encoded word, go to WRITE. Illegal tuple → dropped (no write, addr unchanged), err←1; if in_last go to DONE, else stay.
- WRITE: imem_we=1 with registered addr/wdata; addr←addr+1, count←count+1. Next state is DONE if the tuple had in_last or addr was all-ones (overflow: err←1, no wrap), else ACCEPT.
- DONE: done=1 for one cycle, go to IDLE.
- Illegal: in_kind ≥ 5 (always checked); range/alignment per Configuration.
- start outside IDLE is ignored.

## Timing
- Reset (async, immediate): state=IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0, count=0.
- Handshake completes on the rising edge with in_valid&in_ready; imem_we is asserted the cycle immediately after. in_ready is low during WRITE, so throughput is one word per 2 cycles.
- in_ready and imem_we are never high in the same cycle.
- done asserts the cycle after the final WRITE (or after an illegal last tuple in ACCEPT); count holds its final value until the next start.
- Reset mid-WRITE drops the pending word; no partial write occurs after rst_n falls.

## Configuration
- ENCODER_RANGE_CHECK_EN defined: I-ALU/LOAD/STORE tuples with in_imm[12]≠in_imm[11] (outside the signed 12-bit range) and BRANCH tuples with in_imm[0]=1 are illegal (dropped, err set).
- Not defined: no immediate checks; the immediate is truncated to the format's bits (in_imm[0] ignored for BRANCH); err is set only for illegal kind and address overflow.

## Test plan
- start base_addr=0x10; tuples addi x1,x0,5 then add x3,x1,x2 (last) → writes 0x00500093 @0x10, 0x002081B3 @0x11; done pulses; count=2; err=0.
- Single tuple sw x2,8(x1) then lw x5,0(x1) last → 0x0020A423, then 0x0000A283 at consecutive addresses.
- beq x1,x2,imm=-4 (last) → 0xFE208EE3; with macro, imm=-3 → no write, err=1, done pulses, count=0.
- in_kind=6 mid-stream between two legal tuples → only 2 writes at consecutive addresses, err=1.
- base_addr=0xFE, 3 tuples none last → writes @0xFE, 0xFF, then done, err=1, count=2, third tuple never accepted.
- rst_n low during WRITE → imem_we drops immediately; all outputs at reset values; subsequent start works normally.
